// File: rtl/led_pkg.sv
// Shared types and helpers for the LED matrix renderer.
// FSM states, colour classes, log2 helper and GRB packing.
package led_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_OFF,
    C_GREEN,
    C_YELLOW,
    C_RED,
    C_WHITE
  } colour_t;

  localparam logic [23:0] GRB_OFF = 24'h000000;

  function automatic int clog2_fn(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [23:0] grb_pack(
    input logic [7:0] g,
    input logic [7:0] r,
    input logic [7:0] b
  );
    return {g, r, b};
  endfunction

  function automatic logic [23:0] colour_grb(
    input colour_t    c,
    input logic [7:0] br
  );
    logic [23:0] v;
    v = GRB_OFF;
    unique case (c)
      C_GREEN:  v = grb_pack(br, 8'h00, 8'h00);
      C_YELLOW: v = grb_pack(br, br, 8'h00);
      C_RED:    v = grb_pack(8'h00, br, 8'h00);
      C_WHITE:  v = grb_pack(br, br, br);
      default:  v = GRB_OFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_bar_tracker.sv
// Per-band bar/peak/hold history with one update port and a read port.
// Ports: i_we/i_wr_band/i_lvl update; i_rd_band -> o_bar/o_peak (comb).
module led_bar_tracker
  import led_pkg::*;
#(
  parameter  int BANDS     = 32,
  parameter  int HEIGHT    = 8,
  parameter  int PEAK_HOLD = 24,
  localparam int AW        = clog2_fn(BANDS),
  localparam int LW        = clog2_fn(HEIGHT + 1),
  localparam int HW        = clog2_fn(PEAK_HOLD + 1)
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_band,
  input  logic [LW-1:0] i_lvl,
  input  logic [AW-1:0] i_rd_band,
  output logic [LW-1:0] o_bar,
  output logic [LW-1:0] o_peak
);

  logic [LW-1:0] r_bar  [BANDS];
  logic [LW-1:0] r_peak [BANDS];
  logic [HW-1:0] r_hold [BANDS];

  logic [LW-1:0] w_bar;
  logic [LW-1:0] w_peak;
  logic [HW-1:0] w_hold;
  logic [LW-1:0] w_bar_dec;
  logic [LW-1:0] w_peak_dec;
  logic [LW-1:0] w_bar_nxt;
  logic [LW-1:0] w_peak_nxt;
  logic [HW-1:0] w_hold_nxt;

  assign w_bar  = r_bar[i_wr_band];
  assign w_peak = r_peak[i_wr_band];
  assign w_hold = r_hold[i_wr_band];

  always_comb begin
    w_bar_dec  = (w_bar == '0) ? '0 : w_bar - LW'(1);
    w_peak_dec = (w_peak == '0) ? '0 : w_peak - LW'(1);
    w_bar_nxt  = (i_lvl > w_bar_dec) ? i_lvl : w_bar_dec;
    w_peak_nxt = w_peak;
    w_hold_nxt = w_hold;
    if (i_lvl >= w_peak) begin
      w_peak_nxt = i_lvl;
      w_hold_nxt = HW'(PEAK_HOLD);
    end else if (w_hold != '0) begin
      w_hold_nxt = w_hold - HW'(1);
    end else begin
      // the marker never sinks below the bar it sits on
      w_peak_nxt = (w_peak_dec > w_bar_nxt) ? w_peak_dec : w_bar_nxt;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANDS; i++) begin
        r_bar[i]  <= '0;
        r_peak[i] <= '0;
        r_hold[i] <= '0;
      end
    end else if (i_we) begin
      r_bar[i_wr_band]  <= w_bar_nxt;
      r_peak[i_wr_band] <= w_peak_nxt;
      r_hold[i_wr_band] <= w_hold_nxt;
    end
  end

  assign o_bar  = r_bar[i_rd_band];
  assign o_peak = r_peak[i_rd_band];

endmodule

// File: rtl/led_matrix_renderer.sv
// Spectrum-to-LED-matrix renderer: reads bands, tracks bars, streams GRB.
// Ports: spec_rd_* read side, pix_* valid/ready stream, status pulses.
module led_matrix_renderer
  import led_pkg::*;
#(
  parameter  int         BANDS      = 32,
  parameter  int         HEIGHT     = 8,
  parameter  int         MAG_SHIFT  = 12,
  parameter  int         SERPENTINE = 1,
  parameter  int         PEAK_HOLD  = 24,
  parameter  logic [7:0] BRIGHT     = 8'h20,
  localparam int         AW         = clog2_fn(BANDS)
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          spec_frame_stb,
  output logic [AW-1:0] spec_rd_addr,
  output logic          spec_rd_en,
  input  logic [15:0]   spec_rd_data,
  input  logic          spec_rd_data_valid,
  output logic [23:0]   pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sof,
  output logic          pix_eof,
  output logic          frame_done,
  output logic          overrun
);

  localparam int LW = clog2_fn(HEIGHT + 1);
  localparam int RW = clog2_fn(HEIGHT);
  localparam logic [15:0]   H16  = 16'(HEIGHT);
  localparam logic [LW-1:0] TH_G = LW'(HEIGHT / 2);
  localparam logic [LW-1:0] TH_Y = LW'((3 * HEIGHT) / 4);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_band;
  logic [LW-1:0] r_lvl;
  logic [AW-1:0] r_col;
  logic [RW-1:0] r_idx;
  logic [23:0]   r_pix_data;
  logic          r_pix_valid;
  logic          r_pix_sof;
  logic          r_pix_eof;
  logic          r_overrun;

  logic [15:0]   w_shift;
  logic [LW-1:0] w_lvl;
  logic          w_last_band;
  logic          w_hs;
  logic          w_load_first;
  logic          w_adv;
  logic          w_we;
  logic          w_cap;
  logic [AW-1:0] w_nxt_col;
  logic [RW-1:0] w_nxt_idx;
  logic          w_nxt_last;
  logic [RW-1:0] w_row;
  logic [LW-1:0] w_row_l;
  logic [LW-1:0] w_bar;
  logic [LW-1:0] w_peak;
  logic          w_lit;
  logic          w_pk;
  colour_t       w_cls;
  logic [23:0]   w_colour;

  assign w_shift     = spec_rd_data >> MAG_SHIFT;
  assign w_lvl       = (w_shift > H16) ? LW'(HEIGHT) : w_shift[LW-1:0];
  assign w_last_band = (r_band == AW'(BANDS - 1));
  assign w_hs        = r_pix_valid & pix_ready;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = 1'b0;
    w_adv        = 1'b0;
    w_we         = 1'b0;
    w_cap        = 1'b0;
    unique case (r_state)
      S_IDLE:   if (spec_frame_stb) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (spec_rd_data_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_we = 1'b1;
        if (w_last_band) begin
          w_load_first = 1'b1;
          w_state_nxt  = S_EMIT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          if (r_pix_eof) w_state_nxt = S_DONE;
          else           w_adv = 1'b1;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_band    <= '0;
      r_lvl     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= spec_frame_stb & (r_state != S_IDLE);
      if (w_cap) r_lvl <= w_lvl;
      if (r_state == S_IDLE && spec_frame_stb) begin
        r_band <= '0;
      end else if (w_we && !w_last_band) begin
        r_band <= r_band + AW'(1);
      end
    end
  end

  led_bar_tracker #(
    .BANDS     (BANDS),
    .HEIGHT    (HEIGHT),
    .PEAK_HOLD (PEAK_HOLD)
  ) u_trk (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_wr_band (r_band),
    .i_lvl     (r_lvl),
    .i_rd_band (w_nxt_col),
    .o_bar     (w_bar),
    .o_peak    (w_peak)
  );

  // position of the pixel about to be loaded into the output register
  always_comb begin
    w_nxt_col = r_col;
    w_nxt_idx = r_idx + RW'(1);
    if (w_load_first) begin
      w_nxt_col = '0;
      w_nxt_idx = '0;
    end else if (r_idx == RW'(HEIGHT - 1)) begin
      w_nxt_col = r_col + AW'(1);
      w_nxt_idx = '0;
    end
  end

  assign w_nxt_last = (w_nxt_col == AW'(BANDS - 1)) &&
                      (w_nxt_idx == RW'(HEIGHT - 1));

  // odd columns run top-down when the strip snakes
  assign w_row   = (SERPENTINE != 0 && w_nxt_col[0]) ?
                   RW'(HEIGHT - 1) - w_nxt_idx : w_nxt_idx;
  assign w_row_l = LW'(w_row);

  assign w_lit = (w_row_l < w_bar);
  assign w_pk  = (w_peak > w_bar) && (w_row_l == w_peak - LW'(1));

  always_comb begin
    w_cls = C_OFF;
    unique case (1'b1)
      w_lit && (w_row_l < TH_G):                      w_cls = C_GREEN;
      w_lit && (w_row_l >= TH_G) && (w_row_l < TH_Y): w_cls = C_YELLOW;
      w_lit && (w_row_l >= TH_Y):                     w_cls = C_RED;
      !w_lit && w_pk:                                 w_cls = C_WHITE;
      default:                                        w_cls = C_OFF;
    endcase
  end

  assign w_colour = colour_grb(w_cls, BRIGHT);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eof   <= 1'b0;
      r_col       <= '0;
      r_idx       <= '0;
    end else if (w_load_first || w_adv) begin
      r_pix_data  <= w_colour;
      r_pix_valid <= 1'b1;
      r_pix_sof   <= w_load_first;
      r_pix_eof   <= w_nxt_last;
      r_col       <= w_nxt_col;
      r_idx       <= w_nxt_idx;
    end else if (r_state == S_EMIT && w_hs && r_pix_eof) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eof   <= 1'b0;
    end
  end

  assign spec_rd_en   = (r_state == S_FETCH);
  assign spec_rd_addr = r_band;
  assign pix_data     = r_pix_data;
  assign pix_valid    = r_pix_valid;
  assign pix_sof      = r_pix_sof;
  assign pix_eof      = r_pix_eof;
  assign frame_done   = (r_state == S_DONE);
  assign overrun      = r_overrun;

endmodule
